// File: rtl/seg7_digit_scan.sv
// Four-digit multiplexed 7-segment scanner with load handshake and frame-aligned updates.
// Optional leading-zero blanking is enabled by defining SEG7_SCAN_LZB_EN.
module seg7_digit_scan #(
   parameter int unsigned CLK_DIV  = 1000,
   parameter int unsigned DEAD_CYC = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        load,
   input  logic [15:0] load_data,
   output logic        load_ready,
   output logic [3:0]  digit_val,
   output logic [3:0]  digit_sel,
   output logic [3:0]  digit_sel_oeb
);

   localparam int unsigned   CW       = $clog2(CLK_DIV);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
   localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYC);

   logic [CW-1:0] cnt;
   logic [1:0]    idx;
   logic [15:0]   disp_reg;
   logic [15:0]   pend_reg;
   logic          pend;
   logic          slot_end;
   logic          frame_end;
   logic          accept;
   logic [3:0]    cur_nib;
   logic          blank;

   assign slot_end   = (cnt == CNT_LAST);
   assign frame_end  = slot_end && (idx == 2'd3);
   assign load_ready = ~pend;
   assign accept     = load && load_ready;
   assign cur_nib    = disp_reg[{idx, 2'b00} +: 4];

`ifdef SEG7_SCAN_LZB_EN
   // lead_zero[k]: nibbles k..3 are all zero; digit 0 is never blanked
   logic [3:0] lead_zero;
   assign lead_zero[3] = (disp_reg[15:12] == 4'h0);
   assign lead_zero[2] = lead_zero[3] && (disp_reg[11:8] == 4'h0);
   assign lead_zero[1] = lead_zero[2] && (disp_reg[7:4] == 4'h0);
   assign lead_zero[0] = 1'b0;
   assign blank        = lead_zero[idx];
`else
   assign blank = 1'b0;
`endif

   always_comb begin
      digit_sel = '1;
      if ((cnt >= CNT_DEAD) && !blank) digit_sel[idx] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt           <= '0;
         idx           <= '0;
         disp_reg      <= '0;
         pend_reg      <= '0;
         pend          <= 1'b0;
         digit_val     <= '0;
         digit_sel_oeb <= '1;
      end else begin
         digit_sel_oeb <= '0;
         digit_val     <= cur_nib;
         cnt           <= slot_end ? '0 : cnt + CW'(1);
         if (slot_end) idx <= idx + 2'd1;
         // accept requires pend low, so a load landing on a frame boundary waits a full frame
         if (frame_end && pend) begin
            disp_reg <= pend_reg;
            pend     <= 1'b0;
         end else if (accept) begin
            pend_reg <= load_data;
            pend     <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seg7_digit_scan.sv
// Self-checking bench for seg7_digit_scan (CLK_DIV=8, DEAD_CYC=2): directed scenarios
// plus randomized traffic against a cycle-count based reference model.
module tb_seg7_digit_scan;

   localparam int CLK_DIV  = 8;
   localparam int DEAD_CYC = 2;
   localparam int FRAME    = 4 * CLK_DIV;
`ifdef SEG7_SCAN_LZB_EN
   localparam bit LZB = 1'b1;
`else
   localparam bit LZB = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset_n;
   logic        load;
   logic [15:0] load_data;
   logic        load_ready;
   logic [3:0]  digit_val;
   logic [3:0]  digit_sel;
   logic [3:0]  digit_sel_oeb;

   seg7_digit_scan #(.CLK_DIV(CLK_DIV), .DEAD_CYC(DEAD_CYC)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .load          (load),
      .load_data     (load_data),
      .load_ready    (load_ready),
      .digit_val     (digit_val),
      .digit_sel     (digit_sel),
      .digit_sel_oeb (digit_sel_oeb)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // model: t counts cycles since reset; slot/index/frame follow from plain division
   int          t;
   logic [15:0] m_disp;
   logic [15:0] m_pval;
   bit          m_pend;
   logic [3:0]  m_dv;
   logic [3:0]  m_oeb;

   function automatic logic [3:0] nib(input logic [15:0] v, input int k);
      return v[k*4 +: 4];
   endfunction

   function automatic int slot_idx(input int tt);
      return (tt / CLK_DIV) % 4;
   endfunction

   function automatic logic [3:0] exp_sel();
      int k;
      k = slot_idx(t);
      if ((t % CLK_DIV) < DEAD_CYC) return 4'b1111;
      if (LZB && k >= 1 && (m_disp >> (4 * k)) == 16'h0) return 4'b1111;
      return ~(4'b0001 << k);
   endfunction

   task automatic tick();
      @(posedge clk);
      if (!reset_n) begin
         t = 0; m_disp = '0; m_pval = '0; m_pend = 1'b0; m_dv = '0; m_oeb = 4'hF;
      end else begin
         m_dv  = nib(m_disp, slot_idx(t));
         m_oeb = 4'h0;
         if ((t % FRAME) == FRAME - 1 && m_pend) begin
            m_disp = m_pval;
            m_pend = 1'b0;
         end else if (load && !m_pend) begin
            m_pval = load_data;
            m_pend = 1'b1;
         end
         t++;
      end
      #1;
   endtask

   task automatic advance_to(input int target);
      while (t < target) tick();
   endtask

   task automatic test_reset();
      reset_n = 1'b0; load = 1'b0; load_data = '0;
      repeat (3) tick();
      n_cmp++; if (digit_sel !== 4'b1111) begin n_bad++; $display("FAIL reset_sel got=%b exp=1111", digit_sel); end
      n_cmp++; if (digit_val !== 4'h0) begin n_bad++; $display("FAIL reset_val got=%h exp=0", digit_val); end
      n_cmp++; if (load_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", load_ready); end
      n_cmp++; if (digit_sel_oeb !== 4'b1111) begin n_bad++; $display("FAIL reset_oeb got=%b exp=1111", digit_sel_oeb); end
      reset_n = 1'b1;
   endtask

   task automatic test_idle_scan();
      logic [3:0] exp;
      for (int i = 0; i < 2 * CLK_DIV; i++) begin
         if ((t % CLK_DIV) < DEAD_CYC) exp = 4'b1111;
         else if (t < CLK_DIV)         exp = 4'b1110;
         else                          exp = LZB ? 4'b1111 : 4'b1101;
         n_cmp++; if (digit_sel !== exp) begin n_bad++; $display("FAIL idle_sel t=%0d got=%b exp=%b", t, digit_sel, exp); end
         n_cmp++; if (digit_val !== 4'h0) begin n_bad++; $display("FAIL idle_val t=%0d got=%h exp=0", t, digit_val); end
         n_cmp++; if (load_ready !== 1'b1) begin n_bad++; $display("FAIL idle_ready t=%0d got=%b exp=1", t, load_ready); end
         n_cmp++; if (digit_sel_oeb !== ((t == 0) ? 4'b1111 : 4'b0000)) begin
            n_bad++; $display("FAIL idle_oeb t=%0d got=%b", t, digit_sel_oeb);
         end
         tick();
      end
   endtask

   task automatic test_load();
      int b;
      logic [15:0] shown;
      load = 1'b1; load_data = 16'h1234;
      tick();
      load = 1'b0;
      n_cmp++; if (load_ready !== 1'b0) begin n_bad++; $display("FAIL load_ready_drop got=%b exp=0", load_ready); end
      b = t - (t % FRAME) + FRAME;
      while (t < b) begin
         n_cmp++; if (digit_val !== 4'h0) begin n_bad++; $display("FAIL load_early_val t=%0d got=%h exp=0", t, digit_val); end
         tick();
      end
      n_cmp++; if (load_ready !== 1'b1) begin n_bad++; $display("FAIL load_ready_rise got=%b exp=1", load_ready); end
      n_cmp++; if (digit_val !== 4'h0) begin n_bad++; $display("FAIL load_boundary_val got=%h exp=0", digit_val); end
      for (int k = 0; k < 4; k++) begin
         advance_to(b + k * CLK_DIV + 4);
         shown[k*4 +: 4] = digit_val;
      end
      n_cmp++; if (shown !== 16'h1234) begin n_bad++; $display("FAIL load_frame got=%h exp=1234", shown); end
   endtask

   task automatic test_back_to_back();
      int b;
      int waited;
      logic [15:0] shown;
      b = t - (t % FRAME) + FRAME;
      advance_to(b + 4);
      load = 1'b1; load_data = 16'hABCD;
      tick();
      load_data = 16'h5678;
      repeat (3) tick();
      load = 1'b0;
      n_cmp++; if (load_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_ready_busy got=%b exp=0", load_ready); end
      advance_to(b + FRAME + 1);
      n_cmp++; if (load_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_after got=%b exp=1", load_ready); end
      for (int k = 0; k < 4; k++) begin
         advance_to(b + FRAME + k * CLK_DIV + 4);
         shown[k*4 +: 4] = digit_val;
      end
      n_cmp++; if (shown !== 16'hABCD) begin n_bad++; $display("FAIL b2b_first got=%h exp=abcd", shown); end
      waited = 0;
      while (load_ready !== 1'b1 && waited < 100) begin tick(); waited++; end
      n_cmp++; if (load_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_wait_ready got=%b exp=1", load_ready); end
      load = 1'b1; load_data = 16'h5678;
      tick();
      load = 1'b0;
      b = t - (t % FRAME) + FRAME;
      for (int k = 0; k < 4; k++) begin
         advance_to(b + k * CLK_DIV + 4);
         shown[k*4 +: 4] = digit_val;
      end
      n_cmp++; if (shown !== 16'h5678) begin n_bad++; $display("FAIL b2b_retry got=%h exp=5678", shown); end
   endtask

   task automatic test_frame_edge();
      int b;
      logic [15:0] shown;
      while ((t % FRAME) != FRAME - 1) tick();
      load = 1'b1; load_data = 16'h2468;
      tick();
      load = 1'b0;
      b = t;
      n_cmp++; if (load_ready !== 1'b0) begin n_bad++; $display("FAIL edge_ready got=%b exp=0", load_ready); end
      for (int k = 0; k < 4; k++) begin
         advance_to(b + k * CLK_DIV + 4);
         shown[k*4 +: 4] = digit_val;
      end
      n_cmp++; if (shown !== 16'h5678) begin n_bad++; $display("FAIL edge_not_early got=%h exp=5678", shown); end
      for (int k = 0; k < 4; k++) begin
         advance_to(b + FRAME + k * CLK_DIV + 4);
         shown[k*4 +: 4] = digit_val;
      end
      n_cmp++; if (shown !== 16'h2468) begin n_bad++; $display("FAIL edge_applied got=%h exp=2468", shown); end
   endtask

   task automatic test_reset_pending();
      int nonzero;
      load = 1'b1; load_data = 16'h9999;
      tick();
      load = 1'b0;
      repeat (3) tick();
      reset_n = 1'b0;
      repeat (2) tick();
      n_cmp++; if (digit_sel !== 4'b1111) begin n_bad++; $display("FAIL rstp_sel got=%b exp=1111", digit_sel); end
      n_cmp++; if (digit_val !== 4'h0) begin n_bad++; $display("FAIL rstp_val got=%h exp=0", digit_val); end
      n_cmp++; if (load_ready !== 1'b1) begin n_bad++; $display("FAIL rstp_ready got=%b exp=1", load_ready); end
      n_cmp++; if (digit_sel_oeb !== 4'b1111) begin n_bad++; $display("FAIL rstp_oeb got=%b exp=1111", digit_sel_oeb); end
      reset_n = 1'b1;
      nonzero = 0;
      repeat (2 * FRAME + 2) begin
         tick();
         if (digit_val !== 4'h0) nonzero++;
      end
      n_cmp++; if (nonzero != 0) begin n_bad++; $display("FAIL rstp_discard nonzero_cycles=%0d exp=0", nonzero); end
   endtask

   task automatic test_lzb();
      logic [3:0] enabled;
      logic [3:0] exp;
      load = 1'b1; load_data = 16'h0050;
      tick();
      load = 1'b0;
      while ((t % FRAME) != 0) tick();
      enabled = '0;
      repeat (FRAME) begin
         enabled = enabled | ~digit_sel;
         tick();
      end
      exp = LZB ? 4'b0011 : 4'b1111;
      n_cmp++; if (enabled !== exp) begin n_bad++; $display("FAIL lzb_enabled got=%b exp=%b", enabled, exp); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 800; i++) begin
         reset_n   = ($urandom_range(199) != 0);
         load      = ($urandom_range(3) == 0);
         load_data = 16'($urandom);
         tick();
         n_cmp++; if (digit_sel !== exp_sel()) begin n_bad++; $display("FAIL rnd_sel t=%0d got=%b exp=%b", t, digit_sel, exp_sel()); end
         n_cmp++; if (digit_val !== m_dv) begin n_bad++; $display("FAIL rnd_val t=%0d got=%h exp=%h", t, digit_val, m_dv); end
         n_cmp++; if (load_ready !== !m_pend) begin n_bad++; $display("FAIL rnd_ready t=%0d got=%b exp=%b", t, load_ready, !m_pend); end
         n_cmp++; if (digit_sel_oeb !== m_oeb) begin n_bad++; $display("FAIL rnd_oeb t=%0d got=%b exp=%b", t, digit_sel_oeb, m_oeb); end
      end
      reset_n = 1'b1;
      load    = 1'b0;
   endtask

   initial begin
      t = 0; m_disp = '0; m_pval = '0; m_pend = 1'b0; m_dv = '0; m_oeb = 4'hF;
      test_reset();
      test_idle_scan();
      test_load();
      test_back_to_back();
      test_frame_edge();
      test_reset_pending();
      test_lzb();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
